cbs_transmit_gate: RTL and testbench

CBS_TRANSMIT_GATE -- requirements
Module: cbs_transmit_gate

---
 rtl/cbs_pkg.sv | 18 +
 rtl/axis_skid_buffer.sv | 66 ++++++
 rtl/cbs_transmit_gate.sv | 114 +++++++++++
 tb/tb_cbs_transmit_gate.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbs_pkg.sv
// Shared types and defaults for the credit-based-shaper transmit gate.
package cbs_pkg;

   localparam int CBS_COUNT_WIDTH = 16;
   localparam int AXIS_DATA_WIDTH = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PASS = 1'b1
   } gate_state_t;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0] data;
      logic                       last;
      logic                       user;
   } axis_beat_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus one overflow slot,
// with a registered space flag so upstream ready never sees m_ready combinationally.
module axis_skid_buffer
   import cbs_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  axis_beat_t i_beat,
   input  logic       i_push,
   output logic       o_space,
   output axis_beat_t o_beat,
   output logic       o_valid,
   input  logic       i_ready
);

   axis_beat_t r_out_beat;
   axis_beat_t r_skid_beat;
   logic       r_out_valid;
   logic       r_skid_valid;
   logic       r_space;
   logic       w_out_free;
   logic       w_skid_valid_nxt;

   assign w_out_free = !r_out_valid || i_ready;

   always_comb begin
      w_skid_valid_nxt = r_skid_valid;
      if (w_out_free) begin
         w_skid_valid_nxt = 1'b0;
      end else if (i_push) begin
         w_skid_valid_nxt = 1'b1;
      end
   end

   // Pushes only arrive while r_space is set, so the skid slot is empty whenever one lands.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_out_beat   <= '0;
         r_skid_beat  <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_space      <= 1'b0;
      end else begin
         r_skid_valid <= w_skid_valid_nxt;
         r_space      <= !w_skid_valid_nxt;
         if (w_out_free) begin
            if (r_skid_valid) begin
               r_out_beat  <= r_skid_beat;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= i_push;
               if (i_push) begin
                  r_out_beat <= i_beat;
               end
            end
         end else if (i_push) begin
            r_skid_beat <= i_beat;
         end
      end
   end

   assign o_space = r_space;
   assign o_beat  = r_out_beat;
   assign o_valid = r_out_valid;

endmodule

// File: rtl/cbs_transmit_gate.sv
// Frame-granular transmit gate: a new frame may only start while send_enable is high,
// frames in flight always complete; reports per-frame byte counts on the output side.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | between frames; input accepted only with send_enable
// ST_PASS | mid-frame on the input side; send_enable ignored
module cbs_transmit_gate
   import cbs_pkg::*;
#(
   parameter int COUNT_WIDTH = CBS_COUNT_WIDTH
)(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [7:0]             s_axis_tdata,
   input  logic                   s_axis_tvalid,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tuser,
   output logic                   s_axis_tready,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   input  logic                   m_axis_tready,
   input  logic                   send_enable,
   output logic                   transmitting,
   output logic                   frame_done,
   output logic [COUNT_WIDTH-1:0] frame_bytes
);

   gate_state_t            r_state;
   gate_state_t            w_state_nxt;
   axis_beat_t             w_s_beat;
   axis_beat_t             w_m_beat;
   logic                   w_space;
   logic                   w_s_ready;
   logic                   w_s_fire;
   logic                   w_m_valid;
   logic                   w_m_fire;
   logic                   r_mid_frame;
   logic                   r_frame_done;
   logic [COUNT_WIDTH-1:0] r_count;
   logic [COUNT_WIDTH-1:0] r_frame_bytes;
   logic [COUNT_WIDTH-1:0] w_count_inc;

   assign w_s_beat  = '{data: s_axis_tdata, last: s_axis_tlast, user: s_axis_tuser};
   assign w_s_ready = (r_state == ST_PASS) ? w_space : (send_enable && w_space);
   assign w_s_fire  = s_axis_tvalid && w_s_ready;
   assign w_m_fire  = w_m_valid && m_axis_tready;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_s_fire) begin
         case (r_state)
            ST_IDLE: if (!s_axis_tlast) w_state_nxt = ST_PASS;
            ST_PASS: if (s_axis_tlast)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   axis_skid_buffer u_skid (
      .clk     (clk),
      .rstn    (rstn),
      .i_beat  (w_s_beat),
      .i_push  (w_s_fire),
      .o_space (w_space),
      .o_beat  (w_m_beat),
      .o_valid (w_m_valid),
      .i_ready (m_axis_tready)
   );

   assign w_count_inc = (&r_count) ? r_count : r_count + COUNT_WIDTH'(1);

   // Counter is zeroed on the tlast handshake, so a next-frame beat in the frame_done cycle counts as 1.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_count       <= '0;
         r_frame_bytes <= '0;
         r_frame_done  <= 1'b0;
         r_mid_frame   <= 1'b0;
      end else begin
         r_frame_done <= w_m_fire && w_m_beat.last;
         if (w_m_fire) begin
            if (w_m_beat.last) begin
               r_count       <= '0;
               r_frame_bytes <= w_count_inc;
               r_mid_frame   <= 1'b0;
            end else begin
               r_count     <= w_count_inc;
               r_mid_frame <= 1'b1;
            end
         end
      end
   end

   assign s_axis_tready = w_s_ready;
   assign m_axis_tdata  = w_m_beat.data;
   assign m_axis_tlast  = w_m_beat.last;
   assign m_axis_tuser  = w_m_beat.user;
   assign m_axis_tvalid = w_m_valid;
   assign transmitting  = w_m_valid || r_mid_frame;
   assign frame_done    = r_frame_done;
   assign frame_bytes   = r_frame_bytes;

endmodule

// File: tb/tb_cbs_transmit_gate.sv
// Bench for cbs_transmit_gate: scoreboarded data path plus frame-level vector table
// and hand-written gating, back-to-back and reset sequences.
module tb_cbs_transmit_gate;

   localparam int TMO = 400;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   typedef struct {
      string name;
      int    len;
      int    ready_pct;
      int    exp_bytes;
      int    exp_sat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast, s_tuser, send_enable;
   logic        m_tready;
   logic        s_tready, m_tvalid, m_tlast, m_tuser, transmitting, frame_done;
   logic [7:0]  m_tdata;
   logic [15:0] frame_bytes;
   logic        s_tready_s, m_tvalid_s, m_tlast_s, m_tuser_s, transmitting_s, frame_done_s;
   logic [7:0]  m_tdata_s;
   logic [3:0]  frame_bytes_s;

   int    n_checks = 0;
   int    n_fail   = 0;
   int    ready_pct = 100;
   int    n_done = 0;
   int    in_cnt = 0;
   bit    exp_done = 0, exp_done_s = 0, prev_stall = 0;
   beat_t prev_beat, mon_ob, mon_ob_s, mon_eb;
   beat_t sb_q[$];
   beat_t sb_s_q[$];
   int    len_q[$];
   int    mon_len;

   always #5 clk = ~clk;

   cbs_transmit_gate u_dut (
      .clk(clk), .rstn(rstn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
      .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
      .send_enable(send_enable), .transmitting(transmitting),
      .frame_done(frame_done), .frame_bytes(frame_bytes)
   );

   cbs_transmit_gate #(.COUNT_WIDTH(4)) u_dut_sat (
      .clk(clk), .rstn(rstn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tuser(s_tuser), .s_axis_tready(s_tready_s),
      .m_axis_tdata(m_tdata_s), .m_axis_tvalid(m_tvalid_s), .m_axis_tlast(m_tlast_s),
      .m_axis_tuser(m_tuser_s), .m_axis_tready(m_tready),
      .send_enable(send_enable), .transmitting(transmitting_s),
      .frame_done(frame_done_s), .frame_bytes(frame_bytes_s)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
      end
   end

   // Scoreboard: input handshakes feed the expected queues, output handshakes drain them.
   always @(negedge clk) begin
      if (!rstn) begin
         sb_q.delete();
         sb_s_q.delete();
         len_q.delete();
         in_cnt     = 0;
         exp_done   = 0;
         exp_done_s = 0;
         prev_stall = 0;
      end else begin
         if (s_tvalid && s_tready) begin
            sb_q.push_back(beat_t'({s_tdata, s_tlast, s_tuser}));
            sb_s_q.push_back(beat_t'({s_tdata, s_tlast, s_tuser}));
            in_cnt++;
            if (s_tlast) begin
               len_q.push_back(in_cnt);
               in_cnt = 0;
            end
         end
         mon_ob   = beat_t'({m_tdata, m_tlast, m_tuser});
         mon_ob_s = beat_t'({m_tdata_s, m_tlast_s, m_tuser_s});
         if (prev_stall) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_beat", mon_ob, prev_beat);
         end
         prev_stall = m_tvalid && !m_tready;
         prev_beat  = mon_ob;
         if (exp_done || frame_done) begin
            check("frame_done", frame_done, exp_done);
            if (frame_done && exp_done) begin
               n_done++;
               if (len_q.size() == 0) fail_now("frame_done_without_input_frame");
               else begin
                  mon_len = len_q.pop_front();
                  check("frame_bytes", frame_bytes, mon_len);
                  check("frame_bytes_sat", frame_bytes_s, (mon_len > 15) ? 15 : mon_len);
               end
            end
         end
         if (exp_done_s || frame_done_s) check("frame_done_sat", frame_done_s, exp_done_s);
         exp_done   = m_tvalid && m_tready && m_tlast;
         exp_done_s = m_tvalid_s && m_tready && m_tlast_s;
         if (m_tvalid && m_tready) begin
            if (sb_q.size() == 0) fail_now("unexpected_output_beat");
            else begin
               mon_eb = sb_q.pop_front();
               check("beat", mon_ob, mon_eb);
            end
         end
         if (m_tvalid_s && m_tready) begin
            if (sb_s_q.size() == 0) fail_now("unexpected_output_beat_sat");
            else begin
               mon_eb = sb_s_q.pop_front();
               check("beat_sat", mon_ob_s, mon_eb);
            end
         end
      end
   end

   // Called and returns at posedge+1 so no handshake edge goes unobserved.
   task automatic drive_beat(input logic [7:0] d, input logic l, input logic u);
      int waited = 0;
      bit acc    = 0;
      s_tdata  = d;
      s_tlast  = l;
      s_tuser  = u;
      s_tvalid = 1'b1;
      while (!acc && waited < TMO) begin
         @(negedge clk);
         acc = s_tready;
         waited++;
         @(posedge clk);
         #1;
      end
      s_tvalid = 1'b0;
      if (!acc) fail_now("input_handshake_timeout");
   endtask

   task automatic send_frame(input int len);
      for (int i = 0; i < len; i++) drive_beat(8'($urandom), (i == len - 1), (i == 0));
   endtask

   task automatic wait_drain();
      int cyc = 0;
      while ((sb_q.size() != 0 || m_tvalid) && cyc < 8000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 8000) fail_now("drain_timeout");
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string p);
      check({p, "_s_tready"}, s_tready, 0);
      check({p, "_m_tvalid"}, m_tvalid, 0);
      check({p, "_m_tdata"}, m_tdata, 0);
      check({p, "_m_tlast"}, m_tlast, 0);
      check({p, "_m_tuser"}, m_tuser, 0);
      check({p, "_transmitting"}, transmitting, 0);
      check({p, "_frame_done"}, frame_done, 0);
      check({p, "_frame_bytes"}, frame_bytes, 0);
      check({p, "_frame_bytes_sat"}, frame_bytes_s, 0);
   endtask

   vec_t       vecs[5];
   logic [7:0] g[4];
   int         hits, tx_hits, d0, beats, tx_gap, cyc_b;
   bit         started;
   int         done_at[$];

   initial begin
      vecs[0] = '{"one_byte", 1, 50, 1, 1};
      vecs[1] = '{"f64", 64, 50, 64, 15};
      vecs[2] = '{"f1500", 1500, 50, 1500, 15};
      vecs[3] = '{"f20_sat", 20, 100, 20, 15};
      vecs[4] = '{"f3", 3, 100, 3, 3};

      rstn = 1'b0; s_tdata = 8'hA5; s_tvalid = 1'b1; s_tlast = 1'b0; s_tuser = 1'b0;
      send_enable = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("por");
      @(posedge clk);
      #1;
      rstn = 1'b1; s_tvalid = 1'b0; send_enable = 1'b0;

      // Gate closed: a pending frame must not be accepted.
      for (int i = 0; i < 4; i++) g[i] = 8'($urandom);
      s_tdata = g[0]; s_tlast = 1'b0; s_tuser = 1'b1; s_tvalid = 1'b1;
      hits = 0; tx_hits = 0;
      repeat (20) begin
         @(negedge clk);
         if (s_tready || s_tready_s) hits++;
         if (transmitting) tx_hits++;
      end
      check("gate_hold_ready_cycles", hits, 0);
      check("gate_idle_transmitting_cycles", tx_hits, 0);
      @(posedge clk);
      #1;
      send_enable = 1'b1;
      drive_beat(g[0], 1'b0, 1'b1);
      @(negedge clk);
      check("gate_latency_valid", m_tvalid, 1);
      check("gate_latency_data", m_tdata, g[0]);
      check("gate_tx_rise", transmitting, 1);
      @(posedge clk);
      #1;
      for (int i = 1; i < 4; i++) drive_beat(g[i], (i == 3), 1'b0);
      wait_drain();
      check("gate_frame_bytes", frame_bytes, 4);

      for (int v = 0; v < 5; v++) begin
         ready_pct   = vecs[v].ready_pct;
         send_enable = 1'b1;
         d0 = n_done;
         send_frame(vecs[v].len);
         wait_drain();
         check({vecs[v].name, "_bytes"}, frame_bytes, vecs[v].exp_bytes);
         check({vecs[v].name, "_bytes_sat"}, frame_bytes_s, vecs[v].exp_sat);
         check({vecs[v].name, "_done_pulses"}, n_done - d0, 1);
      end

      // Enable drops after byte 2 of a 10-byte frame.
      ready_pct = 100; send_enable = 1'b1; d0 = n_done;
      drive_beat(8'($urandom), 1'b0, 1'b1);
      drive_beat(8'($urandom), 1'b0, 1'b0);
      send_enable = 1'b0;
      for (int i = 2; i < 10; i++) drive_beat(8'($urandom), (i == 9), 1'b0);
      s_tdata = 8'h3C; s_tlast = 1'b0; s_tuser = 1'b1; s_tvalid = 1'b1;
      hits = 0;
      repeat (10) begin
         @(negedge clk);
         if (s_tready) hits++;
         @(posedge clk);
         #1;
      end
      check("drop_next_frame_held_cycles", hits, 0);
      check("drop_first_frame_bytes", frame_bytes, 10);
      send_enable = 1'b1;
      send_frame(4);
      wait_drain();
      check("drop_second_frame_bytes", frame_bytes, 4);
      check("drop_done_pulses", n_done - d0, 2);

      // Back-to-back 60-byte frames.
      ready_pct = 100; send_enable = 1'b1;
      beats = 0; tx_gap = 0; started = 0; cyc_b = 0;
      done_at.delete();
      fork
         begin
            send_frame(60);
            send_frame(60);
         end
         begin
            while (beats < 120 && cyc_b < 1000) begin
               @(negedge clk);
               cyc_b++;
               if (frame_done) done_at.push_back(beats);
               if (m_tvalid) started = 1;
               if (started && (!transmitting || !transmitting_s)) tx_gap++;
               if (m_tvalid && m_tready) beats++;
            end
            @(negedge clk);
            if (frame_done) done_at.push_back(beats);
            check("b2b_tx_fall", transmitting, 0);
         end
      join
      @(posedge clk);
      #1;
      check("b2b_tx_gap_cycles", tx_gap, 0);
      check("b2b_out_beats", beats, 120);
      check("b2b_done_count", done_at.size(), 2);
      if (done_at.size() == 2) begin
         check("b2b_done_at_first", done_at[0], 60);
         check("b2b_done_at_second", done_at[1], 120);
      end
      wait_drain();

      // One-cycle reset after byte 5 of a 10-byte frame.
      ready_pct = 100; send_enable = 1'b1;
      for (int i = 0; i < 5; i++) drive_beat(8'($urandom), 1'b0, (i == 0));
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      check_reset("midrst");
      @(posedge clk);
      #1;
      d0 = n_done;
      send_frame(10);
      wait_drain();
      check("midrst_next_frame_bytes", frame_bytes, 10);
      check("midrst_done_pulses", n_done - d0, 1);
      check("midrst_sb_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
